sun_tracker_ctrl: RTL and testbench

// - Upstream command generator for the servo driver: averages east/west light-sensor ADC samples and drives the driver's
//   BTN_0 (cw) / BTN_1 (ccw) command inputs.
// - Closes the loop on the driver's pulse-width output (SERVO_POS) so the servo never runs past its travel limits.
// - Each move is a timed step followed by a settle window; then the block re-measures.

---
 rtl/tracker_defs.sv | 23 ++
 rtl/tracker_timer.sv | 34 +++
 rtl/sun_tracker_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sun_tracker_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_defs.sv
// Shared definitions for the sun tracker: FSM state encodings and servo direction codes.
// Direction codes match the servo driver's own encoding.
package tracker_defs;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAcq    = 3'd1,
        StDecide = 3'd2,
        StMove   = 3'd3,
        StSettle = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DirStop = 2'b00,
        DirCw   = 2'b01,
        DirCcw  = 2'b10
    } dir_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tracker_timer.sv
// Loadable down-counter shared by the MOVE and SETTLE phases.
// DONE is high while the count sits at zero; LOAD takes priority over counting.
module tracker_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic             DONE
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (LOAD) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign DONE = (cnt_q == '0);

endmodule

// File: rtl/sun_tracker_ctrl.sv
// Sun tracker command generator: averages east/west light samples and issues timed cw/ccw
// steps to the servo driver, refusing or aborting moves at the servo travel limits.
module sun_tracker_ctrl
    import tracker_defs::*;
#(
    parameter int unsigned ADC_W      = 12,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned HYST       = 64,
    parameter int unsigned STEP_CYC   = 1_000_000,
    parameter int unsigned SETTLE_CYC = 2_000_000,
    parameter int unsigned POS_MIN    = 500,
    parameter int unsigned POS_MAX    = 2500
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             ADC_VALID,
    input  logic             ADC_CH,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic [31:0]      SERVO_POS,
    output logic             BTN_0,
    output logic             BTN_1,
    output logic             LIMIT_HIT,
    output logic [2:0]       STATE
);

    localparam int unsigned ACC_W   = ADC_W + AVG_LOG2;
    localparam int unsigned CNT_W   = AVG_LOG2 + 1;
    localparam int unsigned DIFF_W  = ADC_W + 1;
    localparam int unsigned TMR_MAX = max_u(STEP_CYC, SETTLE_CYC);
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(2 ** AVG_LOG2);
    localparam logic signed [DIFF_W-1:0] HYST_V   = $signed(DIFF_W'(HYST));
    localparam logic [TMR_W-1:0]         STEP_LD  = TMR_W'(STEP_CYC - 1);
    localparam logic [TMR_W-1:0]         SETL_LD  = TMR_W'(SETTLE_CYC - 1);

    state_e state_q, state_d;
    dir_e   dir_q, dir_d;

    logic [ACC_W-1:0] acc_e_q, acc_e_d, acc_w_q, acc_w_d;
    logic [CNT_W-1:0] cnt_e_q, cnt_e_d, cnt_w_q, cnt_w_d;

    logic btn0_q, btn0_d, btn1_q, btn1_d, limit_q, limit_d;

    logic              tmr_load, tmr_done;
    logic [TMR_W-1:0]  tmr_val;

    logic [ADC_W-1:0]         avg_e, avg_w;
    logic signed [DIFF_W-1:0] diff;
    logic                     want_cw, want_ccw, at_max, at_min, blocked, abort;

    // Compare logic: averages are the accumulators with the fractional bits dropped.
    assign avg_e    = acc_e_q[ACC_W-1:AVG_LOG2];
    assign avg_w    = acc_w_q[ACC_W-1:AVG_LOG2];
    assign diff     = $signed({1'b0, avg_e}) - $signed({1'b0, avg_w});
    assign want_cw  = diff > HYST_V;
    assign want_ccw = diff < -HYST_V;
    assign at_max   = SERVO_POS >= POS_MAX;
    assign at_min   = SERVO_POS <= POS_MIN;
    assign blocked  = (want_cw && at_max) || (want_ccw && at_min);
    assign abort    = ((dir_q == DirCw) && at_max) || ((dir_q == DirCcw) && at_min);

    // Sample accumulation only runs in ACQ; every other state (and EN=0) clears it.
    always_comb begin
        acc_e_d = '0;
        acc_w_d = '0;
        cnt_e_d = '0;
        cnt_w_d = '0;
        if (EN && (state_q == StAcq)) begin
            acc_e_d = acc_e_q;
            acc_w_d = acc_w_q;
            cnt_e_d = cnt_e_q;
            cnt_w_d = cnt_w_q;
            if (ADC_VALID && !ADC_CH && (cnt_e_q != CNT_FULL)) begin
                acc_e_d = acc_e_q + ACC_W'(ADC_DATA);
                cnt_e_d = cnt_e_q + 1'b1;
            end
            if (ADC_VALID && ADC_CH && (cnt_w_q != CNT_FULL)) begin
                acc_w_d = acc_w_q + ACC_W'(ADC_DATA);
                cnt_w_d = cnt_w_q + 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            dir_q   <= DirStop;
            acc_e_q <= '0;
            acc_w_q <= '0;
            cnt_e_q <= '0;
            cnt_w_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            acc_e_q <= acc_e_d;
            acc_w_q <= acc_w_d;
            cnt_e_q <= cnt_e_d;
            cnt_w_q <= cnt_w_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (!EN) begin
            state_d = StIdle;
            dir_d   = DirStop;
        end else begin
            unique case (state_q)
                StIdle: state_d = StAcq;
                StAcq: begin
                    if ((cnt_e_q == CNT_FULL) && (cnt_w_q == CNT_FULL)) begin
                        state_d = StDecide;
                    end
                end
                StDecide: begin
                    state_d = StAcq;
                    dir_d   = DirStop;
                    if (want_cw && !at_max) begin
                        state_d = StMove;
                        dir_d   = DirCw;
                    end else if (want_ccw && !at_min) begin
                        state_d = StMove;
                        dir_d   = DirCcw;
                    end
                end
                StMove: begin
                    if (abort || tmr_done) begin
                        state_d = StSettle;
                        dir_d   = DirStop;
                    end
                end
                StSettle: begin
                    if (tmr_done) begin
                        state_d = StAcq;
                    end
                end
                default: begin
                    state_d = StIdle;
                    dir_d   = DirStop;
                end
            endcase
        end
    end

    // FSM outputs, computed from the upcoming state so they register in step with it
    always_comb begin
        btn0_d   = (state_d == StMove) && (dir_d == DirCw);
        btn1_d   = (state_d == StMove) && (dir_d == DirCcw);
        limit_d  = EN && (((state_q == StDecide) && blocked) || ((state_q == StMove) && abort));
        tmr_load = EN && (((state_q == StDecide) && (state_d == StMove)) ||
                          ((state_q == StMove) && (state_d == StSettle)));
        tmr_val  = (state_d == StMove) ? STEP_LD : SETL_LD;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            btn0_q  <= 1'b0;
            btn1_q  <= 1'b0;
            limit_q <= 1'b0;
        end else begin
            btn0_q  <= btn0_d;
            btn1_q  <= btn1_d;
            limit_q <= limit_d;
        end
    end

    tracker_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LOAD     (tmr_load),
        .LOAD_VAL (tmr_val),
        .DONE     (tmr_done)
    );

    assign BTN_0     = btn0_q;
    assign BTN_1     = btn1_q;
    assign LIMIT_HIT = limit_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_sun_tracker_ctrl.sv
// Bench for sun_tracker_ctrl: decision table plus hand-written abort, enable-drop and reset
// sequences, with expected outputs queued in a scoreboard and popped when the DUT is sampled.
module tb_sun_tracker_ctrl;

    localparam int STEP   = 8;
    localparam int SETTLE = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACQ    = 3'd1;
    localparam logic [2:0] S_DECIDE = 3'd2;
    localparam logic [2:0] S_MOVE   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       b0;
        logic       b1;
        logic       lim;
    } out_t;

    typedef struct {
        string name;
        int    e;
        int    w;
        int    pos;
        out_t  exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic        ADC_VALID;
    logic        ADC_CH;
    logic [11:0] ADC_DATA;
    logic [31:0] SERVO_POS;
    logic        BTN_0, BTN_1, LIMIT_HIT;
    logic [2:0]  STATE;

    out_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[10];

    always #5 CLK = ~CLK;

    sun_tracker_ctrl #(
        .ADC_W      (12),
        .AVG_LOG2   (2),
        .HYST       (64),
        .STEP_CYC   (STEP),
        .SETTLE_CYC (SETTLE),
        .POS_MIN    (500),
        .POS_MAX    (2500)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .ADC_VALID (ADC_VALID),
        .ADC_CH    (ADC_CH),
        .ADC_DATA  (ADC_DATA),
        .SERVO_POS (SERVO_POS),
        .BTN_0     (BTN_0),
        .BTN_1     (BTN_1),
        .LIMIT_HIT (LIMIT_HIT),
        .STATE     (STATE)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] st, input logic b0, input logic b1, input logic lim);
        out_t e;
        e = '{st: st, b0: b0, b1: b1, lim: lim};
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string name);
        out_t got, exp;
        got = '{st: STATE, b0: BTN_0, b1: BTN_1, lim: LIMIT_HIT};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got st=%0d b0=%0b b1=%0b lim=%0b",
                     name, got.st, got.b0, got.b1, got.lim);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL %s: got st=%0d b0=%0b b1=%0b lim=%0b, want st=%0d b0=%0b b1=%0b lim=%0b",
                         name, got.st, got.b0, got.b1, got.lim, exp.st, exp.b0, exp.b1, exp.lim);
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic send(input logic ch, input int val);
        ADC_VALID = 1'b1;
        ADC_CH    = ch;
        ADC_DATA  = 12'(val);
        tick();
        ADC_VALID = 1'b0;
    endtask

    // Sample values base+0..base+3 average to base+1 after truncation.
    task automatic acquire(input int e, input int w);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, e + i);
            send(1'b1, w + i);
        end
    endtask

    task automatic wait_decide(input string name);
        int n;
        n = 0;
        while (STATE != S_DECIDE && n < 6) begin
            tick();
            n++;
        end
        push_exp(S_DECIDE, 1'b0, 1'b0, 1'b0);
        check_out({name, "_decide"});
    endtask

    // Entered with the first MOVE cycle already observed.
    task automatic wait_move_end(input string name);
        int n;
        n = 1;
        tick();
        while ((BTN_0 || BTN_1) && n < 64) begin
            n++;
            tick();
        end
        check_int({name, "_step_len"}, n, STEP);
        push_exp(S_SETTLE, 1'b0, 1'b0, 1'b0);
        check_out({name, "_settle_entry"});
    endtask

    // Entered with `seen` SETTLE cycles already observed; optionally strobes junk east samples.
    task automatic wait_settle(input string name, input int seen, input logic junk);
        int n;
        n = seen;
        ADC_VALID = junk;
        ADC_CH    = 1'b0;
        ADC_DATA  = 12'hfff;
        forever begin
            tick();
            if (STATE != S_SETTLE || n >= 64) break;
            n++;
        end
        ADC_VALID = 1'b0;
        check_int({name, "_settle_len"}, n, SETTLE);
        push_exp(S_ACQ, 1'b0, 1'b0, 1'b0);
        check_out({name, "_back_to_acq"});
    endtask

    initial begin
        tbl[0] = '{"cw",            2000, 1000, 1500, '{S_MOVE, 1'b1, 1'b0, 1'b0}};
        tbl[1] = '{"deadband",      1030, 1000, 1500, '{S_ACQ,  1'b0, 1'b0, 1'b0}};
        tbl[2] = '{"blocked_ccw",   1000, 3000,  500, '{S_ACQ,  1'b0, 1'b0, 1'b1}};
        tbl[3] = '{"ccw",           1000, 3000, 1500, '{S_MOVE, 1'b0, 1'b1, 1'b0}};
        tbl[4] = '{"hyst_eq_pos",   1064, 1000, 1500, '{S_ACQ,  1'b0, 1'b0, 1'b0}};
        tbl[5] = '{"hyst_over_pos", 1065, 1000, 1500, '{S_MOVE, 1'b1, 1'b0, 1'b0}};
        tbl[6] = '{"blocked_cw",    3000, 1000, 2500, '{S_ACQ,  1'b0, 1'b0, 1'b1}};
        tbl[7] = '{"hyst_eq_neg",   1000, 1064, 1500, '{S_ACQ,  1'b0, 1'b0, 1'b0}};
        tbl[8] = '{"ccw_near_min",  1000, 1065,  501, '{S_MOVE, 1'b0, 1'b1, 1'b0}};
        tbl[9] = '{"cw_near_max",   2000, 1000, 2499, '{S_MOVE, 1'b1, 1'b0, 1'b0}};

        // Reset held with EN and strobes active.
        RST_N     = 1'b0;
        EN        = 1'b1;
        ADC_VALID = 1'b1;
        ADC_CH    = 1'b0;
        ADC_DATA  = 12'hfff;
        SERVO_POS = 32'd1500;
        for (int i = 0; i < 3; i++) begin
            push_exp(S_IDLE, 1'b0, 1'b0, 1'b0);
            tick();
            check_out("reset");
        end
        RST_N     = 1'b1;
        ADC_VALID = 1'b0;
        push_exp(S_ACQ, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("after_release");

        // Decision table; settle windows strobe junk east samples that must be ignored.
        for (int k = 0; k < 10; k++) begin
            SERVO_POS = 32'(tbl[k].pos);
            acquire(tbl[k].e, tbl[k].w);
            wait_decide(tbl[k].name);
            exp_q.push_back(tbl[k].exp);
            tick();
            check_out(tbl[k].name);
            if (tbl[k].exp.st == S_MOVE) begin
                wait_move_end(tbl[k].name);
                wait_settle(tbl[k].name, 1, 1'b1);
            end else if (tbl[k].exp.lim) begin
                push_exp(S_ACQ, 1'b0, 1'b0, 1'b0);
                tick();
                check_out({tbl[k].name, "_pulse_end"});
            end
        end

        // Limit reached at the 3rd MOVE cycle.
        SERVO_POS = 32'd1500;
        acquire(2000, 1000);
        wait_decide("abort");
        push_exp(S_MOVE, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("abort_move1");
        tick();
        tick();
        SERVO_POS = 32'd2500;
        push_exp(S_SETTLE, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("abort_hit");
        push_exp(S_SETTLE, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("abort_pulse_end");
        SERVO_POS = 32'd1500;
        wait_settle("abort", 2, 1'b0);

        // EN drop at the 4th MOVE cycle, coinciding with a limit: no LIMIT_HIT.
        acquire(2000, 1000);
        wait_decide("en_drop");
        push_exp(S_MOVE, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("en_drop_move1");
        tick();
        tick();
        tick();
        EN        = 1'b0;
        SERVO_POS = 32'd2500;
        push_exp(S_IDLE, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("en_drop");
        SERVO_POS = 32'd1500;
        push_exp(S_IDLE, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("en_low_hold");
        EN = 1'b1;
        push_exp(S_ACQ, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("re_enable");

        // Six east samples: the two large extras must be dropped, leaving a dead-band result.
        for (int i = 0; i < 4; i++) send(1'b0, 1000);
        send(1'b0, 4095);
        send(1'b0, 4095);
        for (int i = 0; i < 4; i++) send(1'b1, 1000);
        wait_decide("drop_extra");
        push_exp(S_ACQ, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("drop_extra");

        // Reset during MOVE.
        acquire(1000, 3000);
        wait_decide("rst_move");
        push_exp(S_MOVE, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("rst_move1");
        tick();
        RST_N = 1'b0;
        push_exp(S_IDLE, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("rst_mid_move");
        RST_N = 1'b1;
        push_exp(S_ACQ, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("rst_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Both commands high together is never legal.
    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            total++;
            if (BTN_0 && BTN_1) begin
                bad++;
                $display("FAIL btn_exclusive: got BTN_0=%0b BTN_1=%0b, want not both 1", BTN_0, BTN_1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000ns");
        $fatal(1);
    end

endmodule
